// File: rtl/text_console_writer.sv
// Byte-stream text console: interprets printable and control codes and writes
// {attr, 1'b0, char} cells into the 100x30 text RAM, clearing lines as the cursor advances.
module text_console_writer #(
  parameter int         COLS           = 100,
  parameter int         ROWS           = 30,
  parameter logic [7:0] DEFAULT_ATTR   = 8'h0F,
  parameter logic [6:0] BLANK_CHAR     = 7'h20,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk_pix,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        ram_ce,
  output logic [11:0] ram_addr,
  output logic [15:0] ram_data,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ESC, CLEAR_LINE, CLEAR_SCREEN} state_t;

  localparam logic [11:0] COLS_A    = 12'(COLS);
  localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam state_t      RST_STATE = CLEAR_ON_RESET ? CLEAR_SCREEN : IDLE;

  state_t      state_q, state_d;
  logic [6:0]  x_q, x_d;
  logic [4:0]  y_q, y_d;
  logic [11:0] row_base_q, row_base_d;
  logic [7:0]  attr_q, attr_d;
  logic [11:0] clr_addr_q, clr_addr_d;
  logic [11:0] clr_end_q, clr_end_d;
  logic        ram_ce_q, ram_ce_d;
  logic [11:0] ram_addr_q, ram_addr_d;
  logic [15:0] ram_data_q, ram_data_d;

  logic        do_newline;
  logic        nl_wrap;
  logic [4:0]  nl_y;
  logic [11:0] nl_base;

  assign in_ready = (state_q == IDLE) || (state_q == ESC);
  assign busy     = (state_q == CLEAR_LINE) || (state_q == CLEAR_SCREEN);
  assign ram_ce   = ram_ce_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign cursor_x = x_q;
  assign cursor_y = y_q;

  // Destination row of a newline; the row base is stepped, never multiplied.
  assign nl_wrap = (y_q == LAST_ROW);
  assign nl_y    = nl_wrap ? 5'd0 : y_q + 5'd1;
  assign nl_base = nl_wrap ? 12'd0 : row_base_q + COLS_A;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    attr_d     = attr_q;
    clr_addr_d = clr_addr_q;
    clr_end_d  = clr_end_q;
    ram_ce_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    do_newline = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            ram_ce_d   = 1'b1;
            ram_addr_d = row_base_q + {5'd0, x_q};
            ram_data_d = {attr_q, 1'b0, in_data[6:0]};
            if (x_q == LAST_COL) do_newline = 1'b1;
            else                 x_d = x_q + 7'd1;
          end else begin
            case (in_data)
              8'h0A: do_newline = 1'b1;
              8'h0D: x_d = 7'd0;
              8'h08: if (x_q != 7'd0) x_d = x_q - 7'd1;
              8'h0C: begin
                x_d        = 7'd0;
                y_d        = 5'd0;
                row_base_d = 12'd0;
                clr_addr_d = 12'd0;
                clr_end_d  = LAST_CELL;
                state_d    = CLEAR_SCREEN;
              end
              8'h1B:   state_d = ESC;
              default: ;
            endcase
          end
        end
        if (do_newline) begin
          x_d        = 7'd0;
          y_d        = nl_y;
          row_base_d = nl_base;
          clr_addr_d = nl_base;
          clr_end_d  = nl_base + COLS_A - 12'd1;
          state_d    = CLEAR_LINE;
        end
      end
      ESC: begin
        if (in_valid) begin
          attr_d  = in_data;
          state_d = IDLE;
        end
      end
      CLEAR_LINE, CLEAR_SCREEN: begin
        ram_ce_d   = 1'b1;
        ram_addr_d = clr_addr_q;
        ram_data_d = {attr_q, 1'b0, BLANK_CHAR};
        if (clr_addr_q == clr_end_q) state_d = IDLE;
        else                         clr_addr_d = clr_addr_q + 12'd1;
      end
    endcase
  end

  always_ff @(posedge clk_pix or negedge reset) begin
    if (!reset) begin
      state_q    <= RST_STATE;
      x_q        <= 7'd0;
      y_q        <= 5'd0;
      row_base_q <= 12'd0;
      attr_q     <= DEFAULT_ATTR;
      clr_addr_q <= 12'd0;
      clr_end_q  <= LAST_CELL;
      ram_ce_q   <= 1'b0;
      ram_addr_q <= 12'd0;
      ram_data_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      attr_q     <= attr_d;
      clr_addr_q <= clr_addr_d;
      clr_end_q  <= clr_end_d;
      ram_ce_q   <= ram_ce_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
    end
  end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Character-stream front end that fills the 100x30 text RAM scanned by the LCD text display.
- Consumes a byte stream from the CPU/UART side over a valid/ready handshake and interprets printable and control codes.
- Drives the text RAM write port (ram_ce/ram_addr/ram_data) with cells of format {attr[7:0], 1'b0, char[6:0]}, where attr = {bg[3:0], fg[3:0]}.
- Maintains cursor and current attribute; newline wraps to top with a destination-line clear, so no scroll copy is needed.

Parameters:
- COLS, 100: characters per line.
- ROWS, 30: lines per page.
- DEFAULT_ATTR, 8'h0F: attribute after reset (bg 0, fg 15).
- BLANK_CHAR, 7'h20: glyph written by clears.
- CLEAR_ON_RESET, 1: 1 = full-screen clear after reset release; 0 = start IDLE.

Ports:
- clk_pix  in  1  pixel/system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low.
- in_valid  in  1  byte available.
- in_data  in  8  byte.
- in_ready  out  1  writer can accept; a byte transfers when in_valid & in_ready at posedge.
- ram_ce  out  1  text RAM write strobe, one cell per cycle.
- ram_addr  out  12  cell address = row*COLS + col.
- ram_data  out  16  {attr, 1'b0, char[6:0]}.
- cursor_x  out  7  current column, 0..COLS-1.
- cursor_y  out  5  current row, 0..ROWS-1.
- busy  out  1  high while in a CLEAR state.

Behaviour:
- Reset (async, immediate):
  - cursor 0,0; attr = DEFAULT_ATTR; ram_ce = 0; ram_addr = 0; ram_data = 0.
  - State = CLEAR_SCREEN if CLEAR_ON_RESET, else IDLE.
  - Reset mid-clear aborts the clear; ram_ce drops at once.
- States: IDLE, ESC, CLEAR_LINE, CLEAR_SCREEN.
  - in_ready = (state == IDLE || state == ESC), combinational from state.
  - busy = CLEAR_LINE || CLEAR_SCREEN.
- IDLE, byte accepted:
  - 0x20..0x7E:
    - Next cycle: ram_ce = 1, ram_addr = cursor cell, ram_data = {attr, 1'b0, byte[6:0]} (1-cycle registered latency).
    - Then x += 1. If x was COLS-1, do a newline.
  - 0x0A (LF): newline.
  - 0x0D (CR): x = 0, no write.
  - 0x08 (BS): if x > 0 then x -= 1, no write; at x = 0, no change.
  - 0x0C (FF): cursor = 0,0; enter CLEAR_SCREEN.
  - 0x1B (ESC): enter ESC.
  - All other bytes (other controls, 0x7F..0xFF): consumed, ignored.
- ESC: the next accepted byte is loaded into attr; return to IDLE. No write.
- Newline:
  - x = 0; y = y+1, or 0 if y == ROWS-1.
  - Enter CLEAR_LINE for the destination row.
- CLEAR_LINE:
  - ram_ce high for exactly COLS consecutive cycles.
  - Addresses row_base .. row_base+COLS-1 ascending; data = {attr, 1'b0, BLANK_CHAR}.
  - Then IDLE.
- CLEAR_SCREEN:
  - Same pattern over addresses 0 .. COLS*ROWS-1 (3000 cycles), cursor 0,0, then IDLE.
  - attr is unchanged by FF.
- Printable that wraps at x = COLS-1: the character write cycle comes first, then the COLS clear cycles of the next row; the total ram_ce pulse train is contiguous.
- ram_ce = 0 on every cycle not listed above. ram_addr and ram_data hold their last values when ram_ce = 0.
- Row base address is kept incrementally (+COLS, reset to 0 on wrap); no multiplier. Addresses never exceed COLS*ROWS-1.
- in_ready is low throughout clears. in_valid held during a clear is accepted on the first IDLE cycle after it; no byte is dropped or duplicated.

Test Plan:
- Reset with CLEAR_ON_RESET = 1 -> busy = 1 and in_ready = 0 for 3000 cycles; ram_addr sweeps 0..2999, ram_data = 16'h0F20 throughout; then in_ready = 1, cursor 0,0.
- Send "A" (0x41) at cursor 0,0 -> next cycle single ram_ce pulse: addr 0, data 16'h0F41; cursor_x = 1.
- Send 0x1B, 0x1E, 'B' -> attr = 0x1E; write data 16'h1E42 at addr 1; the ESC bytes produce no write.
- Cursor at x = 99, y = 29, send 'Z' -> write addr 2999 (16'h0F5A), then 100 contiguous clears at addrs 0..99; cursor 0,0; in_ready low for exactly 100 cycles.
- Sequence CR, BS at x = 0, 0x07, 0x85 -> no ram_ce, cursor unchanged, each byte accepted in 1 cycle.
- Assert reset low midway through an FF clear (e.g. addr 1500) -> ram_ce = 0 immediately; after release the clear restarts from addr 0 with attr 0x0F.
